// File: rtl/stop_watch_pkg.sv
// stop_watch_pkg: shared BCD widths, limits, time struct and digit validity check
package stop_watch_pkg;
  localparam int DIGIT_W = 4;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  typedef struct packed {
    logic [2*DIGIT_W-1:0] hr;
    logic [2*DIGIT_W-1:0] min;
    logic [2*DIGIT_W-1:0] sec;
  } bcd_time_t;
  function automatic logic bcd_ok(input logic [2*DIGIT_W-1:0] v, input int max);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && (int'(v[7:4]) * 10 + int'(v[3:0])) <= max;
  endfunction
endpackage

// File: rtl/bcd_mod_cnt.sv
// bcd_mod_cnt: two-digit BCD modulo-(MAX+1) up/down counter with load and carry/borrow out
module bcd_mod_cnt
  import stop_watch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 ld,
  input  logic [2*DIGIT_W-1:0] ld_val,
  output logic [2*DIGIT_W-1:0] value,
  output logic                 co
);
  localparam logic [2*DIGIT_W-1:0] TOP = 8'((MAX / 10) * 16 + MAX % 10);
  logic [2*DIGIT_W-1:0] inc, dec;
  assign co  = en && (dir ? value == 8'h00 : value == TOP);
  assign inc = value == TOP ? 8'h00 : value[3:0] == 4'd9 ? {value[7:4] + 4'd1, 4'd0} : value + 8'd1;
  assign dec = value == 8'h00 ? TOP : value[3:0] == 4'd0 ? {value[7:4] - 4'd1, 4'd9} : value - 8'd1;
  always_ff @(posedge clk)
    value <= rst ? '0 : ld ? ld_val : en ? (dir ? dec : inc) : value;
endmodule

// File: rtl/stop_watch_lap.sv
// stop_watch_lap: HH:MM:SS BCD stopwatch/timer with prescaler, preload, lap freeze and event pulses
module stop_watch_lap
  import stop_watch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int HR_MAX   = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       mode_down,
  input  logic       load,
  input  logic [7:0] pre_hr,
  input  logic [7:0] pre_min,
  input  logic [7:0] pre_sec,
  output logic [3:0] hr_h,
  output logic [3:0] hr_l,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       running,
  output logic       lap_active,
  output logic       wrap,
  output logic       done,
  output logic       load_err
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pre_cnt;
  logic mode_dn;
  bcd_time_t live, lap_reg;
  logic sec_co, min_co, hr_co, tick, load_ok, ld, zero, last;
  assign load_ok = load && !running && bcd_ok(pre_hr, HR_MAX) && bcd_ok(pre_min, MIN_MAX) && bcd_ok(pre_sec, SEC_MAX);
  assign tick    = running && !clear && !load && !start_stop && pre_cnt == PW'(TICK_DIV - 1);
  assign ld      = clear || load_ok;
  assign zero    = live == '0;
  assign last    = live == 24'h000001;
  bcd_mod_cnt #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .en(tick), .dir(mode_dn), .ld(ld),
    .ld_val(clear ? 8'h00 : pre_sec), .value(live.sec), .co(sec_co)
  );
  bcd_mod_cnt #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .en(sec_co), .dir(mode_dn), .ld(ld),
    .ld_val(clear ? 8'h00 : pre_min), .value(live.min), .co(min_co)
  );
  bcd_mod_cnt #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .rst(rst), .en(min_co), .dir(mode_dn), .ld(ld),
    .ld_val(clear ? 8'h00 : pre_hr), .value(live.hr), .co(hr_co)
  );
  assign {hr_h, hr_l, min_h, min_l, sec_h, sec_l} = lap_active ? lap_reg : live;
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt    <= '0;
      running    <= 1'b0;
      mode_dn    <= 1'b0;
      lap_active <= 1'b0;
      lap_reg    <= '0;
      wrap       <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        pre_cnt    <= '0;
        running    <= 1'b0;
        lap_active <= 1'b0;
      end else begin
        if (load) begin
          if (load_ok) pre_cnt <= '0;
          else load_err <= 1'b1;
        end else if (start_stop) begin
          if (running) running <= 1'b0;
          else if (!(mode_down && zero)) begin
            running <= 1'b1;
            mode_dn <= mode_down;
          end
        end else if (running) begin
          pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
          wrap    <= hr_co && !mode_dn;
          if (tick && mode_dn && last) begin
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        if (lap) begin
          if (lap_active) lap_active <= 1'b0;
          else if (running) begin
            lap_active <= 1'b1;
            lap_reg    <= live;
          end
        end
      end
    end
  end
endmodule
